// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store initiator for a word-only single-port data memory.
// Define LSU_STATS_EN to add saturating load/store/error counters (stat_* ports).
module lsu_mem_ctrl #(
   parameter int MEM_WORDS = 1024
`ifdef LSU_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
`ifdef LSU_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_loads,
   output logic [CNT_W-1:0] stat_stores,
   output logic [CNT_W-1:0] stat_errs
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        w_err;
   logic [15:0] w_lane;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   always_comb begin
      w_err = 1'b0;
      if (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11) w_err = 1'b1;
      if (req_we && req_funct3[2]) w_err = 1'b1;
      if (req_funct3[1:0] == 2'd1 && req_addr[0]) w_err = 1'b1;
      if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) w_err = 1'b1;
      if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) w_err = 1'b1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_err) w_next = S_RESP;
               else if (req_we && req_funct3 == 3'd2) w_next = S_WR;
               else w_next = S_RD;
            end
         end
         S_RD:    w_next = r_we ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Lane extraction and merge work on the word currently read from memory.
   always_comb begin
      w_lane  = 16'(mem_rdata >> {r_addr[1:0], 3'b000});
      w_load  = mem_rdata;
      w_merge = mem_rdata;
      case (r_funct3)
         3'd0:    w_load = {{24{w_lane[7]}}, w_lane[7:0]};
         3'd1:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
         3'd4:    w_load = {24'd0, w_lane[7:0]};
         3'd5:    w_load = {16'd0, w_lane[15:0]};
         default: w_load = mem_rdata;
      endcase
      if (r_funct3[1:0] == 2'd0) w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      else w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 16'd0;
         r_mem_wdata <= 32'd0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata[15:0];
                  if (w_err) begin
                     r_rdata <= 32'd0;
                     r_err   <= 1'b1;
                  end else if (req_we) begin
                     r_mem_wdata <= req_wdata;
                  end
               end
            end
            S_RD: begin
               if (r_we) r_mem_wdata <= w_merge;
               else begin
                  r_rdata <= w_load;
                  r_err   <= 1'b0;
               end
            end
            S_WR: begin
               r_rdata <= 32'd0;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Response fields are only rewritten on the edge entering RESP, so they hold between responses.
   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign mem_we     = (r_state == S_WR);
   assign mem_addr   = (r_state == S_RD || r_state == S_WR) ? {r_addr[31:2], 2'b00} : 32'd0;
   assign mem_wdata  = r_mem_wdata;

`ifdef LSU_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (r_state == S_RESP) begin
         if (r_err) begin
            if (stat_errs != '1) stat_errs <= stat_errs + 1'b1;
         end else if (r_we) begin
            if (stat_stores != '1) stat_stores <= stat_stores + 1'b1;
         end else begin
            if (stat_loads != '1) stat_loads <= stat_loads + 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the word-only single-port data memory (we/addr/wdata/rdata, combinational read, posedge write, no byte enables).
- Sits between the core's execute stage and data memory.
- Accepts one core request at a time and performs RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores use read-modify-write. Misaligned, illegal and out-of-range accesses are flagged without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached memory. Word index >= MEM_WORDS is out of range.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0/1/2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal funct3 or out-of-range; valid with resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address, bits [1:0] always 0.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word (combinational from mem_addr).

Behaviour:
- States: IDLE, RD, WR, RESP. Encoding is free.
- Reset values: state = IDLE, all latched registers = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Handshake: a request is accepted in the cycle where req_valid && req_ready. The controller latches we, funct3, addr and wdata in that cycle. Core inputs are ignored outside IDLE.
- Error check at acceptance, err = 1 when any of:
  - funct3 is in {3, 6, 7};
  - store with funct3 >= 4;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr[31:2] >= MEM_WORDS.
- Transitions from IDLE on acceptance:
  - err -> RESP.
  - Load -> RD.
  - SW -> WR.
  - SB/SH -> RD.
- RD:
  - mem_addr = {addr[31:2], 2'b00}.
  - Load: select the byte/half by addr[1:0] (little-endian), sign- or zero-extend per funct3, register into resp_rdata, go to RESP.
  - Store: merge wdata[7:0] or wdata[15:0] into mem_rdata at the lane given by addr[1:0], register the result as mem_wdata, go to WR.
- WR:
  - mem_we = 1 for exactly this one cycle.
  - mem_addr is the aligned address; mem_wdata is the merged word (or wdata for SW).
  - Go to RESP.
- RESP: resp_valid = 1 with resp_err/resp_rdata stable for this cycle, then go to IDLE. resp_rdata and resp_err hold their values until the next RESP.
- Latency, with acceptance in cycle T:
  - LW/LB/LH/LBU/LHU: resp_valid at T+2.
  - SW: write edge at end of T+1, resp_valid at T+2.
  - SB/SH: RD at T+1, WR at T+2, resp_valid at T+3.
  - Error: resp_valid at T+1.
- Throughput: at most one access in flight. The next acceptance happens no earlier than the cycle after RESP.
- mem_we is 0 in every state except WR. An erroring request never asserts mem_we.
- Reset asserted mid-operation: immediate return to IDLE, and mem_we drops asynchronously. A write in WR that has not reached its clock edge is abandoned. No resp_valid is produced for the aborted request.
- Back-to-back: a store followed by a load to the same word returns the stored data, because the write completes before RESP.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined:
  - Adds outputs stat_loads, stat_stores and stat_errs, each CNT_W wide.
  - Each increments by 1 in the RESP cycle of the matching access type. Errors count only in stat_errs.
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF -> mem_we high for 1 cycle at T+1 with mem_addr 0x10; resp_valid at T+2, err 0. LW 0x10 -> resp_rdata 0xDEADBEEF at T+2.
- Memory word 0x20 = 0x11223344; SB addr 0x22 wdata 0xAA -> RD then WR with mem_wdata 0x11AA3344, resp_valid at T+3. SH addr 0x20 wdata 0xBEEF -> word becomes 0x11AABEEF.
- Word 0x30 = 0x80FF7F01:
  - LB 0x31 -> 0x0000007F; LB 0x32 -> 0xFFFFFFFF; LBU 0x33 -> 0x00000080.
  - LH 0x32 -> 0xFFFF80FF; LHU 0x32 -> 0x000080FF.
- Errors, each giving resp_valid at T+1 with resp_err 1, mem_we never asserted, resp_rdata 0:
  - LW 0x0002;
  - SH 0x0005;
  - funct3 3;
  - LW 0x1000 (index 1024 with MEM_WORDS = 1024).
- SB 0x40 accepted, rst_n pulsed low during the WR cycle before the clock edge -> word 0x40 unchanged, no resp_valid, req_ready = 1 after reset release.
- With LSU_STATS_EN: 3 loads, 2 stores, 1 error -> stat_loads = 3, stat_stores = 2, stat_errs = 1.
